index_allocator: RTL and testbench
==================================

Name: index_allocator

Overview:
- Slot/tag allocator with an N-entry free bitmap.
- Acquire side: priority-selects a free slot and returns its index over a valid/ready handshake.
- Release side: decodes a returned index back into the bitmap.
- Used for MSHR tags, request IDs and other tag pools in cache and memory-scheduler paths, wherever a consumer hands back indices that a priority select produced.

Parameters:
- N, 8, number of slots; legal range 1..64.
- REVERSE, 0, 0 = lowest free index wins, 1 = highest free index wins.
- LN, LOG2UP(N), index width.
- CW, LOG2UP(N+1), occupancy counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- acquire_valid  in  1  requester wants a slot.
- acquire_ready  out  1  at least one slot free.
- acquire_index  out  LN  slot granted on an acquire fire.
- release_valid  in  1  a slot is being returned.
- release_index  in  LN  index of the returned slot.
- free_mask  out  N  registered free bitmap; 1 = free.
- count  out  CW  registered number of allocated slots.
- full  out  1  registered, count == N.
- empty  out  1  registered, count == 0.

Behaviour:
- Reset (reset==0 at a clk edge):
  - free_mask = all ones, count = 0, empty = 1, full = 0.
  - After reset: acquire_ready = 1; acquire_index = 0 (REVERSE=0) or N-1 (REVERSE=1).
  - Reset mid-operation discards all allocations; pending release_valid in that cycle is ignored.
- Acquire path:
  - acquire_ready = |free_mask, combinational from the register.
  - acquire_index = priority select of free_mask per REVERSE, combinational from the register.
  - acquire_index is stable while acquire_ready = 1 and no fire occurs.
  - acquire_index is don't-care when acquire_ready = 0.
  - Fire = acquire_valid & acquire_ready. On fire, bit acquire_index clears at the next edge.
  - acquire_ready has no combinational dependence on acquire_valid or release inputs.
- Release path:
  - Release is always accepted; there is no ready.
  - On release_valid, the decoded bit of release_index is set at the next edge.
  - Latency: a released slot appears in free_mask / acquire_index one cycle later. There is no same-cycle bypass.
- Same cycle acquire fire and release of different indices: both applied; count unchanged.
- Illegal releases (state and count unchanged; simulation assertion fires):
  - Release of a slot already free (double free).
  - release_index >= N.
  - Release of the index being acquired in the same cycle, which is a double free by construction.
- Full: acquire_ready = 0; acquire_valid may be held; fire occurs the cycle after any release lands.
- Count:
  - +1 on fire only, -1 on a legal release only, net 0 when both occur.
  - Never wraps: the invariant count == N - popcount(free_mask) is asserted every cycle.
- full/empty are registered and derived from next-state count, so they are exact in the same cycle as count.
- N==1: LN=1, acquire_index tied 0, release_index bit ignored beyond range check.

Decomposition:
- Shared package (VX_gpu_pkg or local define header) holds:
  - Slot index typedef sized LN.
  - Allocator-error assertion macro.
- Acquire select reuses the existing VX_priority_encoder (onehot output drives the clear mask; FAST=1).
- Release decode is one natural sub-module: index_decoder.
  - Inputs: LN index + enable.
  - Outputs: N-bit onehot + out-of-range flag.
  - Purely combinational, separately testable.
- Top holds free_mask, count, full/empty registers and the assertions.

Test Plan:
- Reset then acquire_valid=1 for 8 cycles, N=8, REVERSE=0 -> indices 0,1,...,7; count 1..8; full=1 after 8th fire; acquire_ready=0 on cycle 9.
- Full, release_index=5 at cycle t -> free_mask=8'h20 at t+1, acquire_ready=1 at t+1, next acquire returns 5, count back to 8.
- Same-cycle acquire fire (index 2) and release of index 6 with free_mask=8'h04 -> next free_mask=8'h40, count unchanged.
- REVERSE=1, N=8, three acquires from reset -> indices 7,6,5; free_mask=8'h1F.
- Double-free of index 3 while free, and release_index=9 with N=8 -> free_mask and count unchanged; assertion flagged in both cases.
- Reset driven low with 4 slots allocated and release_valid=1 -> next cycle free_mask=all ones, count=0, empty=1, acquire_index=0.

Source files
------------

// File: rtl/index_allocator_pkg.sv
// ---------------------------------------------------------------------------
// index_allocator_pkg
//   Shared definitions for the slot/tag allocator.
//   - log2up()      : index width helper; returns at least 1 so N==1 still
//                     produces a usable one-bit index.
//   - slot_idx_t    : slot index type sized for the largest legal pool
//                     (64). Instances slice it down to their own LN.
//   - alloc_err_e   : classification of a rejected release.
// ---------------------------------------------------------------------------
package index_allocator_pkg;

    localparam int MAX_SLOTS = 64;
    localparam int MAX_LN    = 6;

    typedef logic [MAX_LN-1:0] slot_idx_t;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_RANGE       = 2'd1,  // release_index >= N
        ERR_SAME_CYCLE  = 2'd2,  // released the slot being granted this cycle
        ERR_DOUBLE_FREE = 2'd3   // released a slot that is already free
    } alloc_err_e;

    function automatic int log2up(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/index_decoder.sv
// ---------------------------------------------------------------------------
// index_decoder
//   Turns a returned slot index into a one-hot set mask for the free bitmap.
//   Purely combinational.
//   Ports:
//     index        in  LN  slot index to decode
//     enable       in  1   decode only when set; outputs are zero otherwise
//     onehot       out N   one-hot of index (all zero when out of range)
//     out_of_range out 1   enable && index >= N
// ---------------------------------------------------------------------------
module index_decoder #(
    parameter int N  = 8,
    parameter int LN = 3
) (
    input  logic [LN-1:0] index,
    input  logic          enable,
    output logic [N-1:0]  onehot,
    output logic          out_of_range
);

    // Zero-extend before comparing so non-power-of-two pools catch the
    // unused upper codes.
    logic [31:0] index_wide;
    assign index_wide   = {{(32-LN){1'b0}}, index};
    assign out_of_range = enable && (index_wide >= 32'(N));

    for (genvar gi = 0; gi < N; gi++) begin : g_dec
        assign onehot[gi] = enable && (index == LN'(gi));
    end

endmodule

// File: rtl/index_allocator.sv
// ---------------------------------------------------------------------------
// index_allocator
//   N-entry slot allocator. A priority select over the free bitmap offers one
//   slot on a valid/ready acquire port; returned slots are decoded back into
//   the bitmap. Releases are always accepted; illegal ones are dropped.
//   Ports:
//     clk            in  1   rising-edge clock
//     reset          in  1   synchronous, active low
//     acquire_valid  in  1   requester wants a slot
//     acquire_ready  out 1   at least one slot free (from register only)
//     acquire_index  out LN  slot granted on fire
//     release_valid  in  1   a slot is being returned
//     release_index  in  LN  returned slot
//     free_mask      out N   registered free bitmap, 1 = free
//     count          out CW  registered allocated-slot count
//     full / empty   out 1   registered, count == N / count == 0
//   ASSERT_ILLEGAL gates the simulation check on rejected releases; the
//   rejection itself is always visible on the internal illegal_release net.
// ---------------------------------------------------------------------------
module index_allocator
    import index_allocator_pkg::*;
#(
    parameter int N              = 8,
    parameter int REVERSE        = 0,
    parameter int LN             = log2up(N),
    parameter int CW             = log2up(N + 1),
    parameter bit ASSERT_ILLEGAL = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          acquire_valid,
    output logic          acquire_ready,
    output logic [LN-1:0] acquire_index,
    input  logic          release_valid,
    input  logic [LN-1:0] release_index,
    output logic [N-1:0]  free_mask,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [N-1:0]  free_mask_reg, free_mask_next;
    logic [CW-1:0] count_reg, count_next;
    logic          full_reg, empty_reg;

    logic [N-1:0]  sel_onehot;
    logic [LN-1:0] sel_index;
    logic          fire;
    logic [N-1:0]  acq_mask;
    logic [N-1:0]  rel_onehot;
    logic          rel_out_of_range;
    logic          rel_legal;
    logic [N-1:0]  rel_mask;
    alloc_err_e    release_err;
    logic          illegal_release;

    // Priority select: scan in the losing direction and let each later free
    // bit overwrite, so the last hit is the winner.
    always_comb begin
        int j;
        j          = 0;
        sel_onehot = '0;
        sel_index  = '0;
        for (int i = 0; i < N; i++) begin
            j = (REVERSE != 0) ? i : (N - 1 - i);
            if (free_mask_reg[j]) begin
                sel_onehot    = '0;
                sel_onehot[j] = 1'b1;
                sel_index     = LN'(j);
            end
        end
    end

    assign acquire_ready = |free_mask_reg;
    assign acquire_index = sel_index;
    assign fire          = acquire_valid && acquire_ready;
    assign acq_mask      = fire ? sel_onehot : '0;

    index_decoder #(
        .N  (N),
        .LN (LN)
    ) u_release_dec (
        .index        (release_index),
        .enable       (release_valid),
        .onehot       (rel_onehot),
        .out_of_range (rel_out_of_range)
    );

    // Releasing the slot granted this cycle is caught before the generic
    // double-free test so the error code says what actually happened.
    always_comb begin
        release_err = ERR_NONE;
        if (release_valid) begin
            if (rel_out_of_range) begin
                release_err = ERR_RANGE;
            end else if (|(rel_onehot & acq_mask)) begin
                release_err = ERR_SAME_CYCLE;
            end else if (|(rel_onehot & free_mask_reg)) begin
                release_err = ERR_DOUBLE_FREE;
            end
        end
    end

    assign illegal_release = (release_err != ERR_NONE);
    assign rel_legal       = release_valid && !illegal_release;
    assign rel_mask        = rel_legal ? rel_onehot : '0;

    assign free_mask_next = (free_mask_reg & ~acq_mask) | rel_mask;
    assign count_next     = count_reg + CW'(fire) - CW'(rel_legal);

    always_ff @(posedge clk) begin
        if (!reset) begin
            free_mask_reg <= '1;
            count_reg     <= '0;
            full_reg      <= 1'b0;
            empty_reg     <= 1'b1;
        end else begin
            free_mask_reg <= free_mask_next;
            count_reg     <= count_next;
            // Derived from the next count so they move with count.
            full_reg      <= (count_next == CW'(N));
            empty_reg     <= (count_next == '0);
        end
    end

    assign free_mask = free_mask_reg;
    assign count     = count_reg;
    assign full      = full_reg;
    assign empty     = empty_reg;

    // Occupancy must always agree with the bitmap.
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (int'(count_reg) == N - $countones(free_mask_reg));
        end
    end

    if (ASSERT_ILLEGAL) begin : g_illegal_chk
        always_ff @(posedge clk) begin
            if (reset) begin
                assert (!illegal_release);
            end
        end
    end

endmodule

// File: tb/tb_index_allocator.sv
// ---------------------------------------------------------------------------
// tb_index_allocator
//   dut_a : N=8, REVERSE=0, driven from a table of per-cycle vectors.
//   dut_b : N=8, REVERSE=1, short acquire sequence.
//   dut_c : N=6, REVERSE=0, out-of-range release (an 8-slot pool has no
//           unrepresentable index codes, so a 6-slot pool is used).
//   The illegal-release simulation check is disabled on the instances whose
//   illegal releases are intentional; the bench checks illegal_release itself.
// ---------------------------------------------------------------------------
module tb_index_allocator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- dut_a ----------------
    logic       a_reset, a_av, a_rv;
    logic [2:0] a_ri;
    logic       a_ready, a_full, a_empty;
    logic [2:0] a_idx;
    logic [7:0] a_mask;
    logic [3:0] a_count;

    index_allocator #(.N(8), .REVERSE(0), .ASSERT_ILLEGAL(1'b0)) dut_a (
        .clk           (clk),
        .reset         (a_reset),
        .acquire_valid (a_av),
        .acquire_ready (a_ready),
        .acquire_index (a_idx),
        .release_valid (a_rv),
        .release_index (a_ri),
        .free_mask     (a_mask),
        .count         (a_count),
        .full          (a_full),
        .empty         (a_empty)
    );

    // ---------------- dut_b ----------------
    logic       b_reset, b_av, b_rv;
    logic [2:0] b_ri;
    logic       b_ready, b_full, b_empty;
    logic [2:0] b_idx;
    logic [7:0] b_mask;
    logic [3:0] b_count;

    index_allocator #(.N(8), .REVERSE(1)) dut_b (
        .clk           (clk),
        .reset         (b_reset),
        .acquire_valid (b_av),
        .acquire_ready (b_ready),
        .acquire_index (b_idx),
        .release_valid (b_rv),
        .release_index (b_ri),
        .free_mask     (b_mask),
        .count         (b_count),
        .full          (b_full),
        .empty         (b_empty)
    );

    // ---------------- dut_c ----------------
    logic       c_reset, c_av, c_rv;
    logic [2:0] c_ri;
    logic       c_ready, c_full, c_empty;
    logic [2:0] c_idx;
    logic [5:0] c_mask;
    logic [2:0] c_count;

    index_allocator #(.N(6), .REVERSE(0), .ASSERT_ILLEGAL(1'b0)) dut_c (
        .clk           (clk),
        .reset         (c_reset),
        .acquire_valid (c_av),
        .acquire_ready (c_ready),
        .acquire_index (c_idx),
        .release_valid (c_rv),
        .release_index (c_ri),
        .free_mask     (c_mask),
        .count         (c_count),
        .full          (c_full),
        .empty         (c_empty)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle of dut_a: inputs, then expectations after the edge.
    typedef struct {
        logic       rst_n;
        logic       av;
        logic       rv;
        logic [2:0] ri;
        logic       exp_ill;    // illegal_release during the cycle
        logic [7:0] exp_mask;
        logic [3:0] exp_count;
        logic       exp_full;
        logic       exp_empty;
        logic       exp_ready;
        logic       chk_idx;
        logic [2:0] exp_idx;
    } vec_t;

    vec_t vecs[20];

    initial begin
        //              rst  av  rv  ri  ill  mask   cnt  full empty rdy chk idx
        vecs[0]  = '{1'b1,1'b1,1'b0,3'd0,1'b0,8'hFE,4'd1,1'b0,1'b0,1'b1,1'b1,3'd1};
        vecs[1]  = '{1'b1,1'b1,1'b0,3'd0,1'b0,8'hFC,4'd2,1'b0,1'b0,1'b1,1'b1,3'd2};
        vecs[2]  = '{1'b1,1'b1,1'b0,3'd0,1'b0,8'hF8,4'd3,1'b0,1'b0,1'b1,1'b1,3'd3};
        vecs[3]  = '{1'b1,1'b1,1'b0,3'd0,1'b0,8'hF0,4'd4,1'b0,1'b0,1'b1,1'b1,3'd4};
        vecs[4]  = '{1'b1,1'b1,1'b0,3'd0,1'b0,8'hE0,4'd5,1'b0,1'b0,1'b1,1'b1,3'd5};
        vecs[5]  = '{1'b1,1'b1,1'b0,3'd0,1'b0,8'hC0,4'd6,1'b0,1'b0,1'b1,1'b1,3'd6};
        vecs[6]  = '{1'b1,1'b1,1'b0,3'd0,1'b0,8'h80,4'd7,1'b0,1'b0,1'b1,1'b1,3'd7};
        vecs[7]  = '{1'b1,1'b1,1'b0,3'd0,1'b0,8'h00,4'd8,1'b1,1'b0,1'b0,1'b0,3'd0};
        // held request while full
        vecs[8]  = '{1'b1,1'b1,1'b0,3'd0,1'b0,8'h00,4'd8,1'b1,1'b0,1'b0,1'b0,3'd0};
        // release 5 while full and still requesting: no fire this cycle
        vecs[9]  = '{1'b1,1'b1,1'b1,3'd5,1'b0,8'h20,4'd7,1'b0,1'b0,1'b1,1'b1,3'd5};
        vecs[10] = '{1'b1,1'b1,1'b0,3'd0,1'b0,8'h00,4'd8,1'b1,1'b0,1'b0,1'b0,3'd0};
        vecs[11] = '{1'b1,1'b0,1'b1,3'd2,1'b0,8'h04,4'd7,1'b0,1'b0,1'b1,1'b1,3'd2};
        // acquire 2 and release 6 together
        vecs[12] = '{1'b1,1'b1,1'b1,3'd6,1'b0,8'h40,4'd7,1'b0,1'b0,1'b1,1'b1,3'd6};
        vecs[13] = '{1'b1,1'b0,1'b1,3'd3,1'b0,8'h48,4'd6,1'b0,1'b0,1'b1,1'b1,3'd3};
        // double free of 3
        vecs[14] = '{1'b1,1'b0,1'b1,3'd3,1'b1,8'h48,4'd6,1'b0,1'b0,1'b1,1'b1,3'd3};
        // release of the slot being granted (3)
        vecs[15] = '{1'b1,1'b1,1'b1,3'd3,1'b1,8'h40,4'd7,1'b0,1'b0,1'b1,1'b1,3'd6};
        vecs[16] = '{1'b1,1'b0,1'b1,3'd0,1'b0,8'h41,4'd6,1'b0,1'b0,1'b1,1'b1,3'd0};
        vecs[17] = '{1'b1,1'b0,1'b1,3'd1,1'b0,8'h43,4'd5,1'b0,1'b0,1'b1,1'b1,3'd0};
        vecs[18] = '{1'b1,1'b0,1'b1,3'd2,1'b0,8'h47,4'd4,1'b0,1'b0,1'b1,1'b1,3'd0};
        // reset with 4 allocated and a release pending
        vecs[19] = '{1'b0,1'b0,1'b1,3'd4,1'b0,8'hFF,4'd0,1'b0,1'b1,1'b1,1'b1,3'd0};
    end

    initial begin
        a_reset = 1'b0; a_av = 1'b0; a_rv = 1'b0; a_ri = '0;
        b_reset = 1'b0; b_av = 1'b0; b_rv = 1'b0; b_ri = '0;
        c_reset = 1'b0; c_av = 1'b0; c_rv = 1'b0; c_ri = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;

        // ---- reset state of dut_a ----
        check("rst_mask",  32'(a_mask),  32'h0FF);
        check("rst_count", 32'(a_count), 32'd0);
        check("rst_full",  32'(a_full),  32'd0);
        check("rst_empty", 32'(a_empty), 32'd1);
        check("rst_ready", 32'(a_ready), 32'd1);
        check("rst_index", 32'(a_idx),   32'd0);
        $display("reset: mask=%h count=%0d ready=%0d index=%0d", a_mask, a_count, a_ready, a_idx);

        // ---- table vectors on dut_a ----
        for (int v = 0; v < 20; v++) begin
            a_reset = vecs[v].rst_n;
            a_av    = vecs[v].av;
            a_rv    = vecs[v].rv;
            a_ri    = vecs[v].ri;
            #1;
            check($sformatf("v%0d_illegal", v), 32'(dut_a.illegal_release), 32'(vecs[v].exp_ill));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_mask", v),  32'(a_mask),  32'(vecs[v].exp_mask));
            check($sformatf("v%0d_count", v), 32'(a_count), 32'(vecs[v].exp_count));
            check($sformatf("v%0d_full", v),  32'(a_full),  32'(vecs[v].exp_full));
            check($sformatf("v%0d_empty", v), 32'(a_empty), 32'(vecs[v].exp_empty));
            check($sformatf("v%0d_ready", v), 32'(a_ready), 32'(vecs[v].exp_ready));
            if (vecs[v].chk_idx) begin
                check($sformatf("v%0d_index", v), 32'(a_idx), 32'(vecs[v].exp_idx));
            end
            $display("vec %0d: rst=%0b av=%0b rv=%0b ri=%0d -> mask=%h count=%0d full=%0b empty=%0b ready=%0b index=%0d",
                     v, vecs[v].rst_n, vecs[v].av, vecs[v].rv, vecs[v].ri,
                     a_mask, a_count, a_full, a_empty, a_ready, a_idx);
            @(negedge clk);
        end
        a_reset = 1'b1; a_av = 1'b0; a_rv = 1'b0;

        // ---- dut_b: highest free index wins ----
        check("rev_rst_index", 32'(b_idx), 32'd7);
        for (int k = 0; k < 3; k++) begin
            b_av = 1'b1;
            #1;
            check($sformatf("rev_acq%0d_index", k), 32'(b_idx), 32'(7 - k));
            $display("rev acquire %0d: index=%0d", k, b_idx);
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        b_av = 1'b0;
        check("rev_mask",  32'(b_mask),  32'h1F);
        check("rev_count", 32'(b_count), 32'd3);
        check("rev_empty", 32'(b_empty), 32'd0);

        // ---- dut_c: out-of-range releases ----
        check("n6_rst_mask", 32'(c_mask), 32'h3F);
        for (int r = 6; r < 8; r++) begin
            c_rv = 1'b1;
            c_ri = 3'(r);
            #1;
            check($sformatf("n6_rel%0d_illegal", r), 32'(dut_c.illegal_release), 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("n6_rel%0d_mask", r),  32'(c_mask),  32'h3F);
            check($sformatf("n6_rel%0d_count", r), 32'(c_count), 32'd0);
            $display("n6 release %0d: mask=%h count=%0d", r, c_mask, c_count);
            @(negedge clk);
        end
        c_rv = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
